// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi4_lite_regbank: AW/W/B/AR/R channel signals.
interface axi4_lite_regbank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_W registers, independent
// AW/W capture, byte strobes, SLVERR on out-of-range addresses, and a flat
// copy of the register state for downstream logic.
module axi4_lite_regbank #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi4_lite_regbank_if.slave           bus,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q
);
  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned LSB = $clog2(NB);
  // A single-register bank still uses a 1-bit index field so that a
  // nonzero bit there is reported as out of range.
  localparam int unsigned IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW:0] NR  = NUM_REGS[IW:0];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] upper;
    upper = a >> (LSB + IW);
    return ({1'b0, a[LSB +: IW]} < NR) && (upper == '0);
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[LSB +: IW];
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              rdy_en;
  logic              aw_hold;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_hold;
  logic [DATA_W-1:0] w_data;
  logic [NB-1:0]     w_strb;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, commit;

  assign awready = rdy_en & ~aw_hold;
  assign wready  = rdy_en & ~w_hold;
  assign arready = rdy_en & ~rvalid;
  assign aw_hs   = bus.AWVALID & awready;
  assign w_hs    = bus.WVALID & wready;
  assign ar_hs   = bus.ARVALID & arready;
  assign commit  = aw_hold & w_hold & ~bvalid;

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.ARREADY = arready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;

  // READY outputs stay low during reset and open on the first edge after it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Write path: capture AW and W independently, commit once both are held
  // and no response is outstanding, then present B until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_hold <= 1'b0;
      aw_addr <= '0;
      w_hold  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (aw_hs) begin
        aw_hold <= 1'b1;
        aw_addr <= bus.AWADDR;
      end
      if (w_hs) begin
        w_hold <= 1'b1;
        w_data <= bus.WDATA;
        w_strb <= bus.WSTRB;
      end
      if (bvalid && bus.BREADY) bvalid <= 1'b0;
      if (commit) begin
        aw_hold <= 1'b0;
        w_hold  <= 1'b0;
        bvalid  <= 1'b1;
        if (in_range(aw_addr)) begin
          bresp <= RESP_OKAY;
          for (int unsigned b = 0; b < NB; b++)
            if (w_strb[b]) regs[idx_of(aw_addr)][b*8 +: 8] <= w_data[b*8 +: 8];
        end else begin
          bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read path: register data/response on AR handshake, hold until RREADY.
  // Sampling regs here sees the pre-commit value on a same-cycle collision.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (in_range(bus.ARADDR)) begin
        rdata <= regs[idx_of(bus.ARADDR)];
        rresp <= RESP_OKAY;
      end else begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end
    end else if (rvalid && bus.RREADY) begin
      rvalid <= 1'b0;
    end
  end

  // Flat view of the register state.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Self-checking bench for axi4_lite_regbank: directed table, hand-written
// timing sequences and randomized traffic against an array-based model.
module tb_axi4_lite_regbank;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 36;
  localparam int unsigned NREG = 16;
  localparam logic [31:0] RV   = 32'h1234_5678;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [NREG*DW-1:0] regs_q;

  axi4_lite_regbank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  axi4_lite_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREG), .RESET_VAL(RV)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .regs_q(regs_q)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mdl [NREG];

  typedef struct {
    logic [35:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [35:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: handshake not seen, expected within 50 cycles", name);
  endtask

  // Reference model: registers are 4-byte words at consecutive word addresses
  // starting at 0; anything at or beyond NREG words is an error.
  function automatic bit m_in_range(input logic [35:0] a);
    return (a >> 2) < 36'(NREG);
  endfunction

  function automatic logic [1:0] m_write(input logic [35:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
    int w;
    if (!m_in_range(a)) return 2'b10;
    w = int'(a >> 2);
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[w][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [35:0] a);
    if (!m_in_range(a)) return 32'h0;
    return mdl[int'(a >> 2)];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREG; i++) mdl[i] = RV;
  endfunction

  task automatic chk_regs();
    for (int i = 0; i < NREG; i++)
      chk($sformatf("regs_q[%0d]", i), 64'(regs_q[i*DW +: DW]), 64'(mdl[i]));
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [35:0] a, input int dly);
    bit r;
    repeat (dly) step();
    bus.AWADDR = a;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = bus.AWREADY;
      step();
      if (r) begin
        bus.AWVALID = 1'b0;
        return;
      end
    end
    bus.AWVALID = 1'b0;
    timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit r;
    repeat (dly) step();
    bus.WDATA = d;
    bus.WSTRB = s;
    bus.WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = bus.WREADY;
      step();
      if (r) begin
        bus.WVALID = 1'b0;
        return;
      end
    end
    bus.WVALID = 1'b0;
    timeout("w_handshake");
  endtask

  // Write with BREADY high: response must appear exactly one cycle after the
  // later of the two handshakes.
  task automatic do_write(input logic [35:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, output logic [1:0] resp);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    chk("bvalid_before_commit", 64'(bus.BVALID), 64'd0);
    step();
    chk("bvalid_latency", 64'(bus.BVALID), 64'd1);
    resp = bus.BRESP;
  endtask

  task automatic do_read(input logic [35:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit r;
    bus.ARADDR = a;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = bus.ARREADY;
      step();
      if (r) begin
        bus.ARVALID = 1'b0;
        chk("rvalid_latency", 64'(bus.RVALID), 64'd1);
        d = bus.RDATA;
        resp = bus.RRESP;
        return;
      end
    end
    bus.ARVALID = 1'b0;
    timeout("ar_handshake");
    d = '0;
    resp = '0;
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd, old;
    logic [35:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    tbl[0] = '{36'h4,         32'hDEADBEEF, 4'hF, 2'b00, 36'h4,  32'hDEADBEEF, 2'b00};
    tbl[1] = '{36'h8,         32'hAABBCCDD, 4'h5, 2'b00, 36'h8,  32'h11BB33DD, 2'b00};
    tbl[2] = '{36'h40,        32'hCAFEF00D, 4'hF, 2'b10, 36'h40, 32'h00000000, 2'b10};
    tbl[3] = '{36'h1_0000_0004, 32'h0BADF00D, 4'hF, 2'b10, 36'h4, 32'hDEADBEEF, 2'b00};
    tbl[4] = '{36'h3F,        32'hFFFFFFFF, 4'h8, 2'b00, 36'h3C, 32'hFF345678, 2'b00};
    tbl[5] = '{36'h7,         32'h00000000, 4'h0, 2'b00, 36'h4,  32'hDEADBEEF, 2'b00};
    tbl[6] = '{36'h0,         32'h01020304, 4'h3, 2'b00, 36'h2,  32'h12340304, 2'b00};

    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0;  bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    m_reset();

    // Reset: held for 3 cycles, READY opens one cycle after release.
    repeat (3) step();
    chk("rst_awready", 64'(bus.AWREADY), 64'd0);
    chk("rst_bvalid", 64'(bus.BVALID), 64'd0);
    chk("rst_rvalid", 64'(bus.RVALID), 64'd0);
    ARESET = 1'b0;
    step();
    chk("post_rst_awready", 64'(bus.AWREADY), 64'd1);
    chk("post_rst_wready", 64'(bus.WREADY), 64'd1);
    chk("post_rst_arready", 64'(bus.ARREADY), 64'd1);
    chk("post_rst_bresp", 64'(bus.BRESP), 64'd0);
    chk("post_rst_rdata", 64'(bus.RDATA), 64'd0);
    chk_regs();

    // W three cycles before AW.
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    chk("t3_wready_n1", 64'(bus.WREADY), 64'd0);
    step();
    chk("t3_wready_n2", 64'(bus.WREADY), 64'd0);
    step();
    chk("t3_wready_n3", 64'(bus.WREADY), 64'd0);
    bus.AWADDR = 36'h8; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    chk("t3_bvalid_early", 64'(bus.BVALID), 64'd0);
    chk("t3_wready_held", 64'(bus.WREADY), 64'd0);
    step();
    chk("t3_bvalid", 64'(bus.BVALID), 64'd1);
    chk("t3_bresp", 64'(bus.BRESP), 64'd0);
    chk("t3_wready_back", 64'(bus.WREADY), 64'd1);
    void'(m_write(36'h8, 32'h11223344, 4'hF));
    chk_regs();
    step();
    chk("t3_bvalid_clear", 64'(bus.BVALID), 64'd0);

    // Directed table: aligned, partial, out-of-range, upper bits, odd addresses.
    for (int i = 0; i < 7; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, i % 3, (i * 2) % 3, br);
      chk($sformatf("tbl%0d_bresp", i), 64'(br), 64'(tbl[i].bresp));
      void'(m_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb));
      chk_regs();
      do_read(tbl[i].raddr, rd, rr);
      chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].rdata));
      chk($sformatf("tbl%0d_rresp", i), 64'(rr), 64'(tbl[i].rresp));
    end

    // B backpressure; a second write is captured but waits for B to drain.
    step();
    bus.BREADY = 1'b0;
    bus.AWADDR = 36'hC; bus.WDATA = 32'h600DCAFE; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    step();
    chk("t5_bvalid", 64'(bus.BVALID), 64'd1);
    void'(m_write(36'hC, 32'h600DCAFE, 4'hF));
    bus.AWADDR = 36'h40; bus.WDATA = 32'h0; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("t5_awready_held", 64'(bus.AWREADY), 64'd0);
    chk("t5_wready_held", 64'(bus.WREADY), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid_stall", 64'(bus.BVALID), 64'd1);
      chk("t5_bresp_stall", 64'(bus.BRESP), 64'd0);
      step();
    end
    bus.BREADY = 1'b1;
    step();
    chk("t5_bvalid_drain", 64'(bus.BVALID), 64'd0);
    step();
    chk("t5_bvalid_second", 64'(bus.BVALID), 64'd1);
    chk("t5_bresp_second", 64'(bus.BRESP), 64'd2);
    chk_regs();
    step();

    // R backpressure.
    bus.RREADY = 1'b0;
    bus.ARADDR = 36'hC; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rvalid_stall", 64'(bus.RVALID), 64'd1);
      chk("t5_rdata_stall", 64'(bus.RDATA), 64'(m_rdata(36'hC)));
      chk("t5_arready_stall", 64'(bus.ARREADY), 64'd0);
      step();
    end
    bus.RREADY = 1'b1;
    step();
    chk("t5_rvalid_drain", 64'(bus.RVALID), 64'd0);
    chk("t5_arready_back", 64'(bus.ARREADY), 64'd1);

    // Read of reg1 in the same cycle as a commit to it returns the old value.
    old = m_rdata(36'h4);
    bus.AWADDR = 36'h5; bus.WDATA = 32'h5A5A0001; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 36'h4; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    chk("t6_bvalid", 64'(bus.BVALID), 64'd1);
    chk("t6_rvalid", 64'(bus.RVALID), 64'd1);
    chk("t6_rdata_old", 64'(bus.RDATA), 64'(old));
    void'(m_write(36'h5, 32'h5A5A0001, 4'hF));
    step();
    do_read(36'h4, rd, rr);
    chk("t6_rdata_new", 64'(rd), 64'h5A5A0001);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      a = 36'($urandom_range(0, 'h4F));
      if ($urandom_range(0, 15) == 0) a = a | 36'h1_0000_0000;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), br);
        chk("rnd_bresp", 64'(br), 64'(m_write(a, d, s)));
        chk_regs();
      end else begin
        do_read(a, rd, rr);
        chk("rnd_rdata", 64'(rd), 64'(m_rdata(a)));
        chk("rnd_rresp", 64'(rr), m_in_range(a) ? 64'd0 : 64'd2);
      end
    end

    // Reset while a response is pending drops it immediately.
    step();
    bus.BREADY = 1'b0;
    bus.AWADDR = 36'h10; bus.WDATA = 32'hFEEDFACE; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    step();
    chk("t6_rst_bvalid_pre", 64'(bus.BVALID), 64'd1);
    #2 ARESET = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_bvalid", 64'(bus.BVALID), 64'd0);
    chk("t6_rst_awready", 64'(bus.AWREADY), 64'd0);
    chk_regs();
    #2 ARESET = 1'b0;
    bus.BREADY = 1'b1;
    step();
    chk("t6_rst_awready_back", 64'(bus.AWREADY), 64'd1);
    chk("t6_rst_bvalid_after", 64'(bus.BVALID), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
